// File: rtl/stream_port_scheduler_if.sv
// Bundle of the N-source input streams and the single arbitrated output stream.
// The slave view belongs to the scheduler; the master view belongs to whatever drives it.
interface stream_port_scheduler_if #(
    parameter int unsigned S_DATA_COUNT = 3,
    parameter int unsigned T_DATA_WIDTH = 8
);
    localparam int unsigned T_ID___WIDTH = $clog2(S_DATA_COUNT);

    logic [S_DATA_COUNT-1:0]              s_valid_i;
    logic [S_DATA_COUNT*T_DATA_WIDTH-1:0] s_data_i;
    logic [S_DATA_COUNT-1:0]              s_last_i;
    logic [S_DATA_COUNT-1:0]              s_ready_o;
    logic                                 m_valid_o;
    logic [T_DATA_WIDTH-1:0]              m_data_o;
    logic                                 m_last_o;
    logic [T_ID___WIDTH-1:0]              m_id_o;
    logic                                 m_ready_i;

    modport master (
        output s_valid_i, s_data_i, s_last_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o, m_last_o, m_id_o
    );

    modport slave (
        input  s_valid_i, s_data_i, s_last_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o, m_last_o, m_id_o
    );
endinterface

// File: rtl/stream_port_scheduler.sv
// Packet-locked round-robin scheduler: N source streams share one registered output port.
// A grant is held from the first beat until the beat carrying last has been accepted.
module stream_port_scheduler #(
    parameter int unsigned S_DATA_COUNT = 3,
    parameter int unsigned T_DATA_WIDTH = 8
) (
    input logic                   clk_i,
    input logic                   rst_i,
    stream_port_scheduler_if.slave bus
);
    localparam int unsigned T_ID___WIDTH = $clog2(S_DATA_COUNT);

    typedef logic [T_ID___WIDTH-1:0] id_t;
    typedef enum logic {StIdle, StBusy} state_e;

    state_e                  state_q, state_d;
    id_t                     grant_q, grant_d;
    id_t                     last_grant_q, last_grant_d;
    logic                    m_valid_q, m_valid_d;
    logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                    m_last_q, m_last_d;
    id_t                     m_id_q, m_id_d;

    id_t                     pick;
    id_t                     idx;
    logic                    pick_found;
    logic [T_DATA_WIDTH-1:0] src_data;
    logic                    src_valid;
    logic                    src_last;
    logic                    grant_ready;
    logic                    src_hs;
    logic [S_DATA_COUNT-1:0] ready;

    // Round-robin scan starting just after the previously completed grant.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = '0;
        for (int unsigned i = 0; i < S_DATA_COUNT; i++) begin
            idx = id_t'((32'(last_grant_q) + 32'd1 + i) % S_DATA_COUNT);
            if (!pick_found && bus.s_valid_i[idx]) begin
                pick       = idx;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        src_data  = '0;
        src_valid = 1'b0;
        src_last  = 1'b0;
        for (int unsigned k = 0; k < S_DATA_COUNT; k++) begin
            if (grant_q == id_t'(k)) begin
                src_data  = bus.s_data_i[k*T_DATA_WIDTH +: T_DATA_WIDTH];
                src_valid = bus.s_valid_i[k];
                src_last  = bus.s_last_i[k];
            end
        end
    end

    // Output register can take a new beat when empty or draining this cycle.
    assign grant_ready = (state_q == StBusy) && (!m_valid_q || bus.m_ready_i);
    assign src_hs      = grant_ready && src_valid;

    always_comb begin
        ready = '0;
        for (int unsigned k = 0; k < S_DATA_COUNT; k++) begin
            ready[k] = grant_ready && (grant_q == id_t'(k));
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (src_hs && src_last) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_id_d    = m_id_q;
        if (src_hs) begin
            m_valid_d = 1'b1;
            m_data_d  = src_data;
            m_last_d  = src_last;
            m_id_d    = grant_q;
        end else if (bus.m_ready_i) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= id_t'(S_DATA_COUNT - 1);
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            m_id_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
            m_id_q       <= m_id_d;
        end
    end

    assign bus.s_ready_o = ready;
    assign bus.m_valid_o = m_valid_q;
    assign bus.m_data_o  = m_data_q;
    assign bus.m_last_o  = m_last_q;
    assign bus.m_id_o    = m_id_q;
endmodule

// File: tb/tb_stream_port_scheduler.sv
// Directed bench for the stream port scheduler; output beats are matched against a
// scoreboard of {id, last, data} entries queued at each source handshake.
module tb_stream_port_scheduler;
    localparam int unsigned S = 3;
    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [10:0] exp_q[$];

    stream_port_scheduler_if #(.S_DATA_COUNT(S), .T_DATA_WIDTH(W)) bus ();

    stream_port_scheduler #(
        .S_DATA_COUNT(S),
        .T_DATA_WIDTH(W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_src(input int k, input logic [7:0] d, input logic l);
        bus.s_data_i[k*W +: W] = d;
        bus.s_last_i[k]        = l;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Wait up to max_cyc cycles for a source handshake, expect it on src, queue the beat.
    task automatic hs(input int src, input logic [7:0] data, input logic last, input int max_cyc);
        logic got;
        logic [1:0] id;
        got = 1'b0;
        id  = 2'(src);
        for (int n = 0; n < max_cyc && !got; n++) begin
            @(negedge clk);
            if ((bus.s_ready_o & bus.s_valid_i) != '0) got = 1'b1;
        end
        check("hs_seen", 32'(got), 32'd1);
        if (got) begin
            check("grant_onehot", 32'(bus.s_ready_o), 32'd1 << src);
            exp_q.push_back({id, last, data});
        end
        next();
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.m_valid_o === 1'b1 && bus.m_ready_i === 1'b1) begin
            logic [10:0] e;
            check("sb_empty_on_beat", 32'(exp_q.size() == 0), 32'd0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_id", 32'(bus.m_id_o), 32'(e[10:9]));
                check("out_last", 32'(bus.m_last_o), 32'(e[8]));
                check("out_data", 32'(bus.m_data_o), 32'(e[7:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.s_valid_i = 3'b111;
        bus.s_data_i  = '0;
        bus.s_last_i  = '0;
        bus.m_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) set_src(k, 8'h10 + 8'(k), 1'b1);

        // Reset held two edges with all sources valid.
        next();
        next();
        check("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
        check("rst_m_data", 32'(bus.m_data_o), 32'd0);
        check("rst_m_last", 32'(bus.m_last_o), 32'd0);
        check("rst_m_id", 32'(bus.m_id_o), 32'd0);
        check("rst_s_ready", 32'(bus.s_ready_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 32'(bus.s_ready_o), 32'd0);
        next();

        // Fairness: single-beat packets, each followed by one idle cycle.
        hs(0, 8'h10, 1'b1, 1);
        for (int p = 1; p < 5; p++) begin
            @(negedge clk);
            check("idle_gap", 32'(bus.s_ready_o), 32'd0);
            next();
            hs(p % 3, 8'h10 + 8'(p % 3), 1'b1, 1);
        end
        bus.s_valid_i = 3'b000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("idle_no_valid", 32'(bus.s_ready_o), 32'd0);
            next();
        end

        // Packet locking: source 1 holds the port while source 0 waits.
        bus.s_valid_i = 3'b001;
        set_src(0, 8'h30, 1'b1);
        hs(0, 8'h30, 1'b1, 3);
        bus.s_valid_i = 3'b011;
        set_src(0, 8'h0F, 1'b1);
        set_src(1, 8'hA1, 1'b0);
        hs(1, 8'hA1, 1'b0, 3);
        set_src(1, 8'hA2, 1'b0);
        hs(1, 8'hA2, 1'b0, 1);
        bus.s_valid_i = 3'b001;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("lock_gap_ready", 32'(bus.s_ready_o), 32'b010);
            next();
        end
        bus.s_valid_i = 3'b011;
        set_src(1, 8'hA3, 1'b1);
        hs(1, 8'hA3, 1'b1, 1);
        hs(0, 8'h0F, 1'b1, 3);

        // Backpressure on a pending 0x55 beat.
        bus.s_valid_i = 3'b010;
        set_src(1, 8'h55, 1'b0);
        hs(1, 8'h55, 1'b0, 3);
        bus.m_ready_i = 1'b0;
        set_src(1, 8'h66, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.m_valid_o), 32'd1);
            check("bp_data", 32'(bus.m_data_o), 32'h55);
            check("bp_s_ready", 32'(bus.s_ready_o), 32'd0);
            next();
        end
        bus.m_ready_i = 1'b1;
        hs(1, 8'h66, 1'b1, 1);

        // Wrap-around from last grant 2.
        bus.s_valid_i = 3'b100;
        set_src(2, 8'h77, 1'b1);
        hs(2, 8'h77, 1'b1, 3);
        bus.s_valid_i = 3'b101;
        set_src(0, 8'h80, 1'b1);
        hs(0, 8'h80, 1'b1, 3);
        hs(2, 8'h77, 1'b1, 3);

        // Reset mid-packet: the pending beat is dropped, arbitration restarts at 0.
        bus.s_valid_i = 3'b100;
        set_src(2, 8'hB1, 1'b0);
        hs(2, 8'hB1, 1'b0, 3);
        set_src(2, 8'hB2, 1'b0);
        bus.m_ready_i = 1'b0;
        rst = 1'b1;
        next();
        rst           = 1'b0;
        bus.m_ready_i = 1'b1;
        bus.s_valid_i = 3'b111;
        set_src(0, 8'hC0, 1'b1);
        set_src(1, 8'hC1, 1'b1);
        void'(exp_q.pop_back());
        @(negedge clk);
        check("midrst_m_valid", 32'(bus.m_valid_o), 32'd0);
        check("midrst_s_ready", 32'(bus.s_ready_o), 32'd0);
        next();
        hs(0, 8'hC0, 1'b1, 1);
        bus.s_valid_i = 3'b000;

        for (int c = 0; c < 4; c++) next();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("final_m_valid", 32'(bus.m_valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_port_scheduler.md
STREAM_PORT_SCHEDULER -- requirements
Module: stream_port_scheduler

Interface
REQ-001 SHALL have parameter S_DATA_COUNT, default 3: number of source streams competing for one output port; legal values >= 2.
REQ-002 SHALL have parameter T_DATA_WIDTH, default 8: tdata width per beat.
REQ-003 SHALL have localparam T_ID___WIDTH = $clog2(S_DATA_COUNT).
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port s_valid_i, input, S_DATA_COUNT: per-source beat valid.
REQ-007 SHALL have port s_data_i, input, S_DATA_COUNT*T_DATA_WIDTH: packed beats; source k occupies bits [k*T_DATA_WIDTH +: T_DATA_WIDTH].
REQ-008 SHALL have port s_last_i, input, S_DATA_COUNT: per-source end-of-packet flag.
REQ-009 SHALL have port s_ready_o, output, S_DATA_COUNT: per-source beat accept.
REQ-010 SHALL have port m_valid_o, output, 1: output beat valid.
REQ-011 SHALL have port m_data_o, output, T_DATA_WIDTH: output beat.
REQ-012 SHALL have port m_last_o, output, 1: output end-of-packet.
REQ-013 SHALL have port m_id_o, output, T_ID___WIDTH: index of the source that produced the output beat.
REQ-014 SHALL have port m_ready_i, input, 1: downstream accept.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant held by grant_id).
REQ-016 SHALL, in IDLE with |s_valid_i = 1, pick the first set s_valid_i bit scanning from (last_grant+1) mod S_DATA_COUNT upward with wrap-around, register it into grant_id, and enter BUSY on the next edge.
REQ-017 SHALL stay in IDLE while s_valid_i = 0, with s_ready_o = 0.
REQ-018 SHALL drive s_ready_o[grant_id] = BUSY && (!m_valid_o || m_ready_i) and s_ready_o = 0 for every other bit; the combinational path m_ready_i -> s_ready_o is permitted.
REQ-019 SHALL, on a source handshake (s_valid_i[grant_id] && s_ready_o[grant_id]), load the output register: m_valid_o = 1, m_data_o = that source's beat, m_last_o = s_last_i[grant_id], m_id_o = grant_id.
REQ-020 SHALL clear m_valid_o when m_ready_i = 1 and no new source handshake occurs in the same cycle.
REQ-021 SHALL hold m_valid_o, m_data_o, m_last_o and m_id_o constant while m_valid_o = 1 and m_ready_i = 0.
REQ-022 SHALL sustain one beat per cycle inside a packet while m_ready_i = 1 and the granted source keeps s_valid_i high.
REQ-023 SHALL, on a source handshake carrying s_last_i = 1, set last_grant = grant_id and return to IDLE on that edge.
REQ-024 SHALL insert exactly one IDLE cycle between consecutive packets; new arbitration never overlaps a packet.
REQ-025 SHALL hold the grant across gaps in s_valid_i of the granted source (packet locking); there is no timeout.
REQ-026 SHALL ignore s_valid_i, s_data_i and s_last_i of non-granted sources while BUSY.
REQ-027 SHALL treat a single-beat packet (s_last_i = 1 on the first beat) as a complete packet.

Reset
REQ-028 SHALL, while rst_i = 1 at a clock edge, set state = IDLE, last_grant = S_DATA_COUNT-1 (so source 0 is first priority), grant_id = 0, m_valid_o = 0, m_data_o = 0, m_last_o = 0, m_id_o = 0, and s_ready_o = 0.
REQ-029 SHALL, on reset asserted mid-packet, abandon the packet: the pending output beat is dropped and nothing is resumed after release.

Verification
REQ-030 SHALL be verified with this reset scenario: hold rst_i = 1 for 2 cycles with s_valid_i = 3'b111 -> all outputs 0. Release -> IDLE for 1 cycle, then grant_id = 0.
REQ-031 SHALL be verified with this fairness scenario: S=3, s_valid_i = 3'b111 held, all packets 1 beat, m_ready_i = 1 -> m_id_o sequence 0,1,2,0,1, with each beat separated by one IDLE cycle.
REQ-032 SHALL be verified with this locking scenario: source 1 sends a 3-beat packet 8'hA1,8'hA2,8'hA3 (last on 8'hA3) while s_valid_i[0] = 1 throughout -> s_ready_o[0] = 0 until the 8'hA3 handshake. Output order is A1,A2,A3, then source 0.
REQ-033 SHALL be verified with this backpressure scenario: m_ready_i = 0 for 3 cycles with m_data_o = 8'h55 valid -> m_data_o stays 8'h55, m_valid_o stays 1, and s_ready_o = 0 for those 3 cycles. Next data is accepted on the first cycle m_ready_i = 1.
REQ-034 SHALL be verified with this wrap scenario: last_grant = 2, s_valid_i = 3'b101 in IDLE -> grant_id = 0. The next arbitration with s_valid_i = 3'b101 gives grant_id = 2.
REQ-035 SHALL be verified with this mid-packet reset scenario: rst_i pulsed for 1 cycle during beat 2 of a 4-beat packet from source 2 -> m_valid_o = 0 next cycle. Re-arbitration starts from source 0.
